// File: rtl/tsp_pkg.sv
// Shared types and default sizes for the instruction fetch front-end.
package tsp_pkg;

    localparam int INSTR_WIDTH          = 32;
    localparam int INSTR_MEM_ADDR_WIDTH = 10;
    localparam int FIFO_DEPTH           = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } fetch_state_t;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [INSTR_WIDTH-1:0]          instr;
        logic [INSTR_MEM_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Control, instruction-memory and dispatch signals of the fetch queue.
// The master side is the fetch queue; the slave side is its environment
// (program control, instruction memory and the ICU dispatcher).
interface instr_fetch_queue_if #(
    parameter int INSTR_WIDTH          = tsp_pkg::INSTR_WIDTH,
    parameter int INSTR_MEM_ADDR_WIDTH = tsp_pkg::INSTR_MEM_ADDR_WIDTH
);

    // Program control
    logic                            start;
    logic [INSTR_MEM_ADDR_WIDTH-1:0] start_pc;
    logic [INSTR_MEM_ADDR_WIDTH:0]   instr_count;
    logic                            redirect_valid;
    logic [INSTR_MEM_ADDR_WIDTH-1:0] redirect_pc;
    logic                            busy;
    logic                            done;

    // Instruction memory read port
    logic                            instr_req;
    logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_address;
    logic [INSTR_WIDTH-1:0]          instr_in;
    logic                            instr_valid;

    // Dispatch handshake towards the ICU
    logic [INSTR_WIDTH-1:0]          instr_out;
    logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_pc;
    logic                            instr_out_valid;
    logic                            instr_out_ready;

    modport master (
        input  start, start_pc, instr_count, redirect_valid, redirect_pc,
        input  instr_in, instr_valid, instr_out_ready,
        output instr_req, instr_address, instr_out, instr_pc, instr_out_valid,
        output busy, done
    );

    modport slave (
        output start, start_pc, instr_count, redirect_valid, redirect_pc,
        output instr_in, instr_valid, instr_out_ready,
        input  instr_req, instr_address, instr_out, instr_pc, instr_out_valid,
        input  busy, done
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. Push and pop in the same cycle
// are both performed; flush empties the queue and wins over a push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array write.
    // NOTE: the data array has no reset; occupancy alone decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: sequences fetch addresses, issues one-cycle
// latency reads, buffers returned words with their PC and hands them to the
// ICU over valid/ready. Supports bounded programs, redirect and done pulse.
module instr_fetch_queue #(
    parameter int INSTR_WIDTH          = tsp_pkg::INSTR_WIDTH,
    parameter int INSTR_MEM_ADDR_WIDTH = tsp_pkg::INSTR_MEM_ADDR_WIDTH,
    parameter int FIFO_DEPTH           = tsp_pkg::FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
);

    import tsp_pkg::fetch_state_t;
    import tsp_pkg::IDLE;
    import tsp_pkg::FETCH;
    import tsp_pkg::DONE;

    localparam int AW = INSTR_MEM_ADDR_WIDTH;
    localparam int NW = INSTR_MEM_ADDR_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [AW-1:0]          pc;
    } entry_t;

    localparam int EW = $bits(entry_t);

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] req_pc_q;
    logic [NW-1:0] to_issue_q;
    logic [NW-1:0] to_deliver_q;
    logic          inflight_q;

    logic          in_fetch;
    logic          redirect;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    entry_t        push_entry;
    entry_t        head;

    assign in_fetch = (state_q == FETCH);
    assign redirect = in_fetch && bus.redirect_valid;
    assign pop      = !fifo_empty && bus.instr_out_ready;

    // The response in a redirect cycle belongs to the abandoned stream.
    assign push     = bus.instr_valid && inflight_q && !redirect;

    // Buffered words plus the one in flight, after this cycle's pop.
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);

    assign issue = in_fetch && (to_issue_q != '0) && !bus.redirect_valid
                   && (occupancy < (CW+1)'(FIFO_DEPTH)) && !(fifo_full && !pop);

    assign push_entry = '{instr: bus.instr_in, pc: req_pc_q};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state selection: start a program, finish once all words are delivered.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = (bus.instr_count == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (to_deliver_q == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fetch address, issue/delivery counters and the outstanding-request tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= '0;
            req_pc_q     <= '0;
            to_issue_q   <= '0;
            to_deliver_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) req_pc_q <= pc_q;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        pc_q         <= bus.start_pc;
                        to_issue_q   <= bus.instr_count;
                        to_deliver_q <= bus.instr_count;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        // Everything not yet delivered is refetched from the new PC.
                        pc_q         <= bus.redirect_pc;
                        to_issue_q   <= to_deliver_q - NW'(pop);
                        to_deliver_q <= to_deliver_q - NW'(pop);
                    end else begin
                        if (issue) begin
                            pc_q       <= pc_q + AW'(1);
                            to_issue_q <= to_issue_q - NW'(1);
                        end
                        if (pop) to_deliver_q <= to_deliver_q - NW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_req       = issue;
    assign bus.instr_address   = issue ? pc_q : '0;
    assign bus.instr_out_valid = !fifo_empty;
    assign bus.instr_out       = fifo_empty ? '0 : head.instr;
    assign bus.instr_pc        = fifo_empty ? '0 : head.pc;
    assign bus.busy            = in_fetch;
    assign bus.done            = (state_q == DONE);

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch front-end between instruction_memory and icu_dispatcher.
- Sequences the instruction address, issues 1-cycle-latency reads and buffers the returned words in a small FIFO.
- Presents the buffered instructions, each tagged with its PC, to the ICU over a valid/ready handshake.
- Supports program start with a bounded instruction count, redirect (flush and refetch) and completion signalling.

Parameters:
- INSTR_WIDTH, 32, instruction word width.
- INSTR_MEM_ADDR_WIDTH, 10, instruction address width (1024 entries).
- FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state rises on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle program start; ignored while busy.
- start_pc  in  INSTR_MEM_ADDR_WIDTH  first fetch address.
- instr_count  in  INSTR_MEM_ADDR_WIDTH+1  number of instructions to deliver (0..1024).
- redirect_valid  in  1  flush and refetch request from the ICU.
- redirect_pc  in  INSTR_MEM_ADDR_WIDTH  new fetch address.
- instr_req  out  1  read request to instruction memory.
- instr_address  out  INSTR_MEM_ADDR_WIDTH  read address; valid with instr_req.
- instr_in  in  INSTR_WIDTH  read data.
- instr_valid  in  1  read data qualifier; arrives exactly 1 cycle after instr_req.
- instr_out  out  INSTR_WIDTH  FIFO head instruction.
- instr_pc  out  INSTR_MEM_ADDR_WIDTH  PC of the FIFO head.
- instr_out_valid  out  1  FIFO non-empty.
- instr_out_ready  in  1  ICU accepts the head.
- busy  out  1  high in the FETCH state.
- done  out  1  single-cycle pulse when the program has been fully delivered.

Behaviour:
- Reset (rst low, async): state=IDLE, pc=0, to_issue=0, to_deliver=0, FIFO empty, inflight=0. All outputs 0.
- States:
  - IDLE: on start, load pc=start_pc, to_issue=to_deliver=instr_count, go to FETCH. If instr_count=0, go to DONE instead.
  - FETCH: when to_deliver reaches 0 (registered), go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Issue rule, evaluated in FETCH. A request issues when all of the following hold:
  - to_issue>0
  - !redirect_valid
  - count + inflight - pop < FIFO_DEPTH, where pop = instr_out_valid & instr_out_ready.
- On issue: instr_req=1, instr_address=pc, pc<=pc+1 (wraps modulo 2^INSTR_MEM_ADDR_WIDTH), to_issue--, inflight<=1. A cycle without an issue sets inflight<=0.
- Response path:
  - When instr_valid=1 and the cycle is not a redirect cycle, push {instr_in, address of that request} into the FIFO.
  - Track the address of that request in a 1-entry register.
- Latency: request at cycle t, FIFO write at t+1, instr_out_valid at t+2.
- Steady-state throughput: one instruction per cycle with ready held high. No bypass from instr_in to instr_out.
- Handshake:
  - instr_out and instr_pc stay stable while valid && !ready.
  - Each pop decrements to_deliver.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Redirect (FETCH only; ignored in IDLE/DONE), at cycle t:
  - A pop in the same cycle is performed first and counted.
  - The FIFO is flushed.
  - Any instr_valid response arriving in cycle t is discarded.
  - No request is issued in cycle t.
  - pc<=redirect_pc; to_issue<=to_deliver after that cycle's pop.
  - First refetch at t+1.
- instr_out_valid is forced 0 in the cycle after a flush until new data is written.
- start while busy or in DONE: ignored.
- to_issue never underflows. FIFO never overflows by construction; the bench asserts it.

Decomposition:
- Shared package tsp_pkg: INSTR_WIDTH, INSTR_MEM_ADDR_WIDTH, FIFO_DEPTH defaults, fetch_state_t enum {IDLE, FETCH, DONE}, and a fetch_entry_t struct {instr, pc}.
- One sub-module: sync_fifo, parameterised by width and depth, with push, pop, flush, count, full and empty.

Test Plan:
- Sequential delivery:
  - Stimulus: memory[i]=i+0x100; start_pc=0, instr_count=8; ready held 1.
  - Response: instr_out 0x100..0x107 with pc 0..7 on consecutive cycles; first valid 3 cycles after start; done pulses once; busy drops.
- Backpressure:
  - Stimulus: instr_count=10; ready low for 6 cycles mid-stream.
  - Response: at most FIFO_DEPTH entries buffered; instr_req stalls; no loss or duplication; order preserved.
- Redirect:
  - Stimulus: start_pc=0, count=6; after delivering pc 0,1, redirect to pc=20.
  - Response: FIFO flushed and the in-cycle response dropped; next delivered pcs are 20,21,22,23; done after 6 total pops.
- Redirect with simultaneous pop:
  - Stimulus: pop of pc=2 coincides with redirect_valid.
  - Response: pc 2 counts as delivered; remaining 3 are fetched from redirect_pc.
- Wrap and zero count:
  - Stimulus: start_pc=1022, count=4.
  - Response: pcs 1022,1023,0,1.
  - Stimulus: count=0.
  - Response: no instr_req; done pulses the cycle after start.
- Async reset mid-run:
  - Stimulus: assert rst low between clock edges during FETCH.
  - Response: all outputs 0 immediately; a subsequent start runs cleanly.
